dmem_lsu: RTL and testbench

Load/store unit between the multi-cycle core's memory-access step and the word-organised D-memory. Accepts one byte-addressed load/store request at a time, generates word address, byte enables and lane-shifted write data, then returns sign/zero-extended load data. Word-crossing accesses are split into two memory accesses, or rejected, depending on the optional feature. Drives the D-memory pins the core previously drove directly.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_align.sv | 52 +++++
 rtl/dmem_lsu.sv | 191 +++++++++++++++++++
 tb/tb_dmem_lsu.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the D-memory load/store unit.
// Used by dmem_lsu and lsu_align.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_CAP,
    ST_RSP
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } lsu_size_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Right-aligned byte mask for an access size (empty for the reserved code)
  function automatic logic [3:0] size_mask(input lsu_size_e size);
    case (size)
      SZ_B:    size_mask = MASK_B;
      SZ_H:    size_mask = MASK_H;
      SZ_W:    size_mask = MASK_W;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  // Number of bytes moved by an access size (0 for the reserved code)
  function automatic logic [2:0] size_bytes(input lsu_size_e size);
    case (size)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      SZ_W:    size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath of the load/store unit:
//   - store side: byte-enable and lane-shifted write data for either half
//     of a (possibly word-crossing) store
//   - load side: byte extraction from one or two captured words, then
//     sign/zero extension
import lsu_pkg::*;

module lsu_align (
  input  lsu_size_e   size,
  input  logic [1:0]  off,
  input  logic        hi_phase,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_dout,
  input  logic [31:0] ld_lo,
  input  logic [31:0] ld_hi,
  input  logic        ld_unsigned,
  output logic [31:0] ld_data
);

  logic [7:0]  be_wide;
  logic [63:0] dout_wide;
  logic [31:0] ld_win;
  logic        ext_bit;

  // Store: shift across a two-word window; low half feeds the first access,
  // high half holds the bytes that spill into the next word
  always_comb begin
    be_wide   = {4'b0000, size_mask(size)} << off;
    dout_wide = {32'h0000_0000, st_data} << {off, 3'b000};
    st_be     = hi_phase ? be_wide[7:4]     : be_wide[3:0];
    st_dout   = hi_phase ? dout_wide[63:32] : dout_wide[31:0];
  end

  // Load: pick bytes starting at the offset, then extend from the top data bit
  always_comb begin
    ld_win  = 32'({ld_hi, ld_lo} >> {off, 3'b000});
    ext_bit = 1'b0;
    case (size)
      SZ_B: begin
        ext_bit = ~ld_unsigned & ld_win[7];
        ld_data = {{24{ext_bit}}, ld_win[7:0]};
      end
      SZ_H: begin
        ext_bit = ~ld_unsigned & ld_win[15];
        ld_data = {{16{ext_bit}}, ld_win[15:0]};
      end
      default: ld_data = ld_win;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the core memory-access step and word-organised
// D-memory. One byte-addressed request at a time; word-crossing accesses are
// split into two memory accesses when LSU_MISALIGN_SPLIT_EN is defined,
// otherwise they are rejected with RSP_ERR.
import lsu_pkg::*;

module dmem_lsu #(
  parameter int unsigned MEM_AW = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_UNSIGNED,
  input  logic [31:0]       REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERR,
  output logic              D_MEM_CSN,
  output logic [MEM_AW-1:0] D_MEM_ADDR,
  output logic              D_MEM_WEN,
  output logic [3:0]        D_MEM_BE,
  output logic [31:0]       D_MEM_DOUT,
  input  logic [31:0]       D_MEM_DI
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  lsu_size_e         size_q, size_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;
  logic              split_q, split_d;
  logic [1:0]        off_q, off_d;
  logic [MEM_AW-1:0] widx_q, widx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       hi_q, hi_d;
  logic [MEM_AW-1:0] maddr_q, maddr_d;
  logic [31:0]       mdout_q, mdout_d;

  lsu_size_e req_size;
  logic      req_cross;
  logic      req_split;
  logic      req_err;
  logic      in_acc;
  logic      in_rsp;
  logic      st_acc;
  logic [3:0]  st_be;
  logic [31:0] st_dout;
  logic [31:0] ld_data;

  // Address bits above the D-memory word range do not take part in the access
  logic unused_addr_hi;
  assign unused_addr_hi = ^REQ_ADDR[31:MEM_AW+2];

  lsu_align u_align (
    .size        (size_q),
    .off         (off_q),
    .hi_phase    (state_q == ST_ACC1),
    .st_data     (wdata_q),
    .st_be       (st_be),
    .st_dout     (st_dout),
    .ld_lo       (lo_q),
    .ld_hi       (hi_q),
    .ld_unsigned (uns_q),
    .ld_data     (ld_data)
  );

  // Request classification: crossing, split decision, rejection
  always_comb begin
    req_size  = lsu_size_e'(REQ_SIZE);
    req_cross = ({2'b00, REQ_ADDR[1:0]} + {1'b0, size_bytes(req_size)}) > 4'd4;
`ifdef LSU_MISALIGN_SPLIT_EN
    req_split = req_cross;
    req_err   = (req_size == SZ_RSV);
`else
    req_split = 1'b0;
    req_err   = (req_size == SZ_RSV) | req_cross;
`endif
  end

  // Next-state logic, request capture and read-data capture
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    err_d   = err_q;
    split_d = split_q;
    off_d   = off_q;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID && REQ_READY) begin
          we_d    = REQ_WE;
          size_d  = req_size;
          uns_d   = REQ_UNSIGNED;
          err_d   = req_err;
          split_d = req_split;
          off_d   = REQ_ADDR[1:0];
          widx_d  = REQ_ADDR[MEM_AW+1:2];
          wdata_d = REQ_WDATA;
          state_d = req_err ? ST_RSP : ST_ACC0;
        end
      end
      ST_ACC0: begin
        if (split_q)    state_d = ST_ACC1;
        else if (we_q)  state_d = ST_RSP;
        else            state_d = ST_CAP;
      end
      ST_ACC1: begin
        // Synchronous read: the first word's data appears during ACC1
        if (!we_q) lo_d = D_MEM_DI;
        state_d = we_q ? ST_RSP : ST_CAP;
      end
      ST_CAP: begin
        if (split_q) hi_d = D_MEM_DI;
        else         lo_d = D_MEM_DI;
        state_d = ST_RSP;
      end
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory pins and response outputs, derived only from registered state
  always_comb begin
    in_acc = (state_q == ST_ACC0) || (state_q == ST_ACC1);
    in_rsp = (state_q == ST_RSP);
    st_acc = in_acc && we_q;

    REQ_READY = (state_q == ST_IDLE) && !RST;

    case (state_q)
      ST_ACC0: maddr_d = widx_q;
      ST_ACC1: maddr_d = widx_q + MEM_AW'(1);
      default: maddr_d = maddr_q;
    endcase
    mdout_d = st_acc ? st_dout : mdout_q;

    D_MEM_CSN  = !in_acc;
    D_MEM_WEN  = !st_acc;
    D_MEM_BE   = st_acc ? st_be : 4'b0000;
    D_MEM_ADDR = maddr_d;
    D_MEM_DOUT = mdout_d;

    RSP_VALID = in_rsp;
    RSP_ERR   = in_rsp && err_q;
    RSP_RDATA = (in_rsp && !we_q && !err_q) ? ld_data : '0;
  end

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      off_q   <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      maddr_q <= '0;
      mdout_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      split_q <= split_d;
      off_q   <= off_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      maddr_q <= maddr_d;
      mdout_q <= mdout_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a synchronous-read word memory model.
// Expectations follow the build: LSU_MISALIGN_SPLIT_EN defined selects the
// split-access expectations, otherwise crossing accesses expect rejection.
module tb_dmem_lsu;

  localparam int unsigned MEM_AW = 12;

  logic              CLK;
  logic              RST;
  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WE;
  logic [1:0]        REQ_SIZE;
  logic              REQ_UNSIGNED;
  logic [31:0]       REQ_ADDR;
  logic [31:0]       REQ_WDATA;
  logic              RSP_VALID;
  logic [31:0]       RSP_RDATA;
  logic              RSP_ERR;
  logic              D_MEM_CSN;
  logic [MEM_AW-1:0] D_MEM_ADDR;
  logic              D_MEM_WEN;
  logic [3:0]        D_MEM_BE;
  logic [31:0]       D_MEM_DOUT;
  logic [31:0]       D_MEM_DI;

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  int checks;
  int errors;

  dmem_lsu #(.MEM_AW(MEM_AW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .REQ_VALID    (REQ_VALID),
    .REQ_READY    (REQ_READY),
    .REQ_WE       (REQ_WE),
    .REQ_SIZE     (REQ_SIZE),
    .REQ_UNSIGNED (REQ_UNSIGNED),
    .REQ_ADDR     (REQ_ADDR),
    .REQ_WDATA    (REQ_WDATA),
    .RSP_VALID    (RSP_VALID),
    .RSP_RDATA    (RSP_RDATA),
    .RSP_ERR      (RSP_ERR),
    .D_MEM_CSN    (D_MEM_CSN),
    .D_MEM_ADDR   (D_MEM_ADDR),
    .D_MEM_WEN    (D_MEM_WEN),
    .D_MEM_BE     (D_MEM_BE),
    .D_MEM_DOUT   (D_MEM_DOUT),
    .D_MEM_DI     (D_MEM_DI)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous-read memory with byte-lane writes; read returns old data
  always @(posedge CLK) begin
    if (!D_MEM_CSN) begin
      if (!D_MEM_WEN) begin
        for (int i = 0; i < 4; i++)
          if (D_MEM_BE[i]) mem[D_MEM_ADDR][8*i +: 8] <= D_MEM_DOUT[8*i +: 8];
      end
      D_MEM_DI <= mem[D_MEM_ADDR];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Present a request at the current negedge; returns at the negedge of T+1
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    REQ_WE       = we;
    REQ_SIZE     = size;
    REQ_UNSIGNED = uns;
    REQ_ADDR     = addr;
    REQ_WDATA    = wdata;
    REQ_VALID    = 1'b1;
    chk("issue_ready", 32'(REQ_READY), 32'd1);
    step();
    REQ_VALID    = 1'b0;
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rst_addr;
    checks       = 0;
    errors       = 0;
    RST          = 1'b1;
    REQ_VALID    = 1'b0;
    REQ_WE       = 1'b0;
    REQ_SIZE     = 2'd0;
    REQ_UNSIGNED = 1'b0;
    REQ_ADDR     = '0;
    REQ_WDATA    = '0;
    for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = 32'h0;
    mem[12'h041] = 32'hDEADBEEF;
    mem[12'h042] = 32'h11111111;
    mem[12'h080] = 32'h80112233;
    mem[12'hFFF] = 32'hAABBCCDD;
    mem[12'h000] = 32'h11223344;

    // Reset state
    step(); step();
    chk("rst_ready", 32'(REQ_READY), 32'd0);
    chk("rst_csn",   32'(D_MEM_CSN), 32'd1);
    chk("rst_wen",   32'(D_MEM_WEN), 32'd1);
    chk("rst_be",    32'(D_MEM_BE),  32'd0);
    chk("rst_addr",  32'(D_MEM_ADDR), 32'd0);
    chk("rst_dout",  D_MEM_DOUT, 32'd0);
    chk("rst_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rdata", RSP_RDATA, 32'd0);
    chk("rst_err",   32'(RSP_ERR), 32'd0);
    RST = 1'b0;
    #1;
    chk("rel_ready", 32'(REQ_READY), 32'd1);
    step();

    // LW 0x104
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0);
    chk("lw_csn",  32'(D_MEM_CSN), 32'd0);
    chk("lw_wen",  32'(D_MEM_WEN), 32'd1);
    chk("lw_addr", 32'(D_MEM_ADDR), 32'h041);
    chk("lw_be",   32'(D_MEM_BE), 32'd0);
    step();
    chk("lw_cap_valid", 32'(RSP_VALID), 32'd0);
    chk("lw_cap_csn",   32'(D_MEM_CSN), 32'd1);
    step();
    chk("lw_valid", 32'(RSP_VALID), 32'd1);
    chk("lw_rdata", RSP_RDATA, 32'hDEADBEEF);
    chk("lw_err",   32'(RSP_ERR), 32'd0);
    chk("lw_rsp_ready", 32'(REQ_READY), 32'd0);
    step();
    chk("lw_after_valid", 32'(RSP_VALID), 32'd0);
    chk("lw_after_ready", 32'(REQ_READY), 32'd1);

    // SB 0x10B
    issue(1'b1, 2'd0, 1'b0, 32'h0000_010B, 32'h0000_00A5);
    chk("sb_addr", 32'(D_MEM_ADDR), 32'h042);
    chk("sb_be",   32'(D_MEM_BE), 32'h8);
    chk("sb_dout", D_MEM_DOUT, 32'hA500_0000);
    chk("sb_wen",  32'(D_MEM_WEN), 32'd0);
    step();
    chk("sb_valid", 32'(RSP_VALID), 32'd1);
    chk("sb_rdata", RSP_RDATA, 32'd0);
    chk("sb_err",   32'(RSP_ERR), 32'd0);
    chk("sb_hold_dout", D_MEM_DOUT, 32'hA500_0000);
    step();
    chk("sb_mem", mem[12'h042], 32'hA511_1111);

    // LB / LBU / LH / LHU around word 0x80
    issue(1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'h0);
    step(); step();
    chk("lb_rdata", RSP_RDATA, 32'hFFFF_FF80);
    step();
    issue(1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'h0);
    step(); step();
    chk("lbu_rdata", RSP_RDATA, 32'h0000_0080);
    step();
    issue(1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0);
    step(); step();
    chk("lh_rdata", RSP_RDATA, 32'hFFFF_8011);
    step();
    issue(1'b0, 2'd1, 1'b1, 32'h0000_0200, 32'h0);
    step(); step();
    chk("lhu_rdata", RSP_RDATA, 32'h0000_2233);
    step();
    issue(1'b0, 2'd2, 1'b1, 32'h0000_0200, 32'h0);
    step(); step();
    chk("lw_uns_rdata", RSP_RDATA, 32'h8011_2233);
    step();

    // Split LW 0x3FFE with address wrap
    issue(1'b0, 2'd2, 1'b0, 32'h0000_3FFE, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("slw_addr0", 32'(D_MEM_ADDR), 32'hFFF);
    chk("slw_csn0",  32'(D_MEM_CSN), 32'd0);
    step();
    chk("slw_addr1", 32'(D_MEM_ADDR), 32'h000);
    chk("slw_csn1",  32'(D_MEM_CSN), 32'd0);
    step();
    chk("slw_cap_csn",   32'(D_MEM_CSN), 32'd1);
    chk("slw_cap_valid", 32'(RSP_VALID), 32'd0);
    step();
    chk("slw_valid", 32'(RSP_VALID), 32'd1);
    chk("slw_rdata", RSP_RDATA, 32'h3344_AABB);
    chk("slw_err",   32'(RSP_ERR), 32'd0);
`else
    chk("xlw_csn",   32'(D_MEM_CSN), 32'd1);
    chk("xlw_valid", 32'(RSP_VALID), 32'd1);
    chk("xlw_err",   32'(RSP_ERR), 32'd1);
    chk("xlw_rdata", RSP_RDATA, 32'd0);
`endif
    step();

    // Split SH 0x7
    issue(1'b1, 2'd1, 1'b0, 32'h0000_0007, 32'h0000_1234);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("ssh_addr0", 32'(D_MEM_ADDR), 32'h001);
    chk("ssh_be0",   32'(D_MEM_BE), 32'h8);
    chk("ssh_dout0", D_MEM_DOUT, 32'h3400_0000);
    chk("ssh_wen0",  32'(D_MEM_WEN), 32'd0);
    step();
    chk("ssh_addr1", 32'(D_MEM_ADDR), 32'h002);
    chk("ssh_be1",   32'(D_MEM_BE), 32'h1);
    chk("ssh_dout1", D_MEM_DOUT, 32'h0000_0012);
    step();
    chk("ssh_valid", 32'(RSP_VALID), 32'd1);
    chk("ssh_err",   32'(RSP_ERR), 32'd0);
    step();
    chk("ssh_mem1", mem[12'h001], 32'h3400_0000);
    chk("ssh_mem2", mem[12'h002], 32'h0000_0012);
`else
    chk("xsh_csn",   32'(D_MEM_CSN), 32'd1);
    chk("xsh_valid", 32'(RSP_VALID), 32'd1);
    chk("xsh_err",   32'(RSP_ERR), 32'd1);
    step();
    chk("xsh_mem1", mem[12'h001], 32'h0);
`endif

    // Reserved size
    issue(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0);
    chk("rsv_csn",   32'(D_MEM_CSN), 32'd1);
    chk("rsv_valid", 32'(RSP_VALID), 32'd1);
    chk("rsv_err",   32'(RSP_ERR), 32'd1);
    chk("rsv_rdata", RSP_RDATA, 32'd0);
    step();

    // Reset during the first access of a store
`ifdef LSU_MISALIGN_SPLIT_EN
    rst_addr = 32'h0000_0016;
`else
    rst_addr = 32'h0000_0014;
`endif
    issue(1'b1, 2'd2, 1'b0, rst_addr, 32'hCAFE_F00D);
    chk("mid_csn_pre", 32'(D_MEM_CSN), 32'd0);
    RST = 1'b1;
    #1;
    chk("mid_csn",   32'(D_MEM_CSN), 32'd1);
    chk("mid_wen",   32'(D_MEM_WEN), 32'd1);
    chk("mid_be",    32'(D_MEM_BE), 32'd0);
    chk("mid_addr",  32'(D_MEM_ADDR), 32'd0);
    chk("mid_dout",  D_MEM_DOUT, 32'd0);
    chk("mid_ready", 32'(REQ_READY), 32'd0);
    step(); step();
    RST = 1'b0;
    #1;
    chk("mid_rel_ready", 32'(REQ_READY), 32'd1);
    step(); step();
    chk("mid_mem5", mem[12'h005], 32'h0);
    chk("mid_mem6", mem[12'h006], 32'h0);

    // Normal operation after the aborted store
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0);
    step(); step();
    chk("post_valid", 32'(RSP_VALID), 32'd1);
    chk("post_rdata", RSP_RDATA, 32'hDEADBEEF);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
